// File: rtl/vec_store_serializer.sv
// Serializes one LANES x DATA_W vector into LANES sequential memory writes, lane 0 first.
// Optional VSTORE_STRIDE_EN adds a latched address stride input (default stride is 1).
module vec_store_serializer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
`ifdef VSTORE_STRIDE_EN
  input  logic [ADDR_W-1:0]             stride,
`endif
  input  logic [LANES-1:0][DATA_W-1:0]  vec_data,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                        state_reg, state_next;
  logic [CW-1:0]                 count_reg, count_next;
  logic [LANES-1:0][DATA_W-1:0]  vec_reg;
  logic [ADDR_W-1:0]             base_reg;
  logic                          latch_en;
  logic [CW-1:0]                 lane_next;
  logic [ADDR_W-1:0]             addr_offset;

  logic                          we_next;
  logic [ADDR_W-1:0]             addr_next;
  logic [DATA_W-1:0]             wdata_next;
  logic                          busy_next;
  logic                          done_next;

`ifdef VSTORE_STRIDE_EN
  logic [ADDR_W-1:0]             stride_reg;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stride_reg <= '0;
    end else if (latch_en) begin
      stride_reg <= stride;
    end
  end

  // Product is truncated to ADDR_W, so address arithmetic wraps modulo 2^ADDR_W.
  assign addr_offset = ADDR_W'(ADDR_W'(lane_next) * stride_reg);
`else
  assign addr_offset = ADDR_W'(lane_next);
`endif

  assign lane_next = count_reg + CW'(1);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    latch_en   = 1'b0;
    we_next    = mem_we;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    busy_next  = busy;
    done_next  = done;

    case (state_reg)
      IDLE: begin
        we_next   = 1'b0;
        busy_next = 1'b0;
        done_next = 1'b0;
        if (start) begin
          latch_en   = 1'b1;
          state_next = WRITE;
          count_next = '0;
          we_next    = 1'b1;
          addr_next  = base_addr;
          wdata_next = vec_data[0];
          busy_next  = 1'b1;
        end
      end

      WRITE: begin
        // Without mem_ready every output simply holds; stalls may last indefinitely.
        if (mem_ready) begin
          if (count_reg == LAST_LANE) begin
            state_next = DONE;
            we_next    = 1'b0;
            done_next  = 1'b1;
          end else begin
            count_next = lane_next;
            addr_next  = base_reg + addr_offset;
            wdata_next = vec_reg[lane_next];
          end
        end
      end

      DONE: begin
        state_next = IDLE;
        done_next  = 1'b0;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        we_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      vec_reg   <= '0;
      base_reg  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (latch_en) begin
        vec_reg  <= vec_data;
        base_reg <= base_addr;
      end
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule
